cnn_window_gen: RTL and testbench
=================================

Name: cnn_window_gen

Overview:
Streaming 3x3 sliding-window generator that sits directly upstream of the CNN convolution stage. It starts on size_detection_done and accepts a square image in raster order, one pixel word per handshake. It holds two previous rows in line buffers and emits every complete 3x3 window (valid padding, stride 1) with its top-left coordinates. The convolution stage consumes these windows through a valid/ready handshake.

Parameters:
DATA_WIDTH, 32, width of one pixel word; the word is opaque to this block.
MAX_IMAGE_SIZE, 512, maximum image side in pixels; sets line-buffer depth.
MAX_IMAGE_SIZE_LOG2, 9, log2(MAX_IMAGE_SIZE).

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  synchronous, active-high reset.
size_detection_done  in  1  one-cycle start pulse; image_size is sampled on this cycle.
image_size  in  MAX_IMAGE_SIZE_LOG2+1  image side N, in pixels (square image).
pix_valid  in  1  upstream pixel valid.
pix_ready  out  1  block can accept a pixel.
pix_data  in  DATA_WIDTH  pixel word, raster order.
win_valid  out  1  window output valid.
win_ready  in  1  downstream can accept the window.
win_data  out  9*DATA_WIDTH  window element k = 3*dr+dc, carried on bits [k*DATA_WIDTH +: DATA_WIDTH]; dr/dc are row/column offsets from the top-left pixel.
win_row  out  MAX_IMAGE_SIZE_LOG2  top-left row of the window.
win_col  out  MAX_IMAGE_SIZE_LOG2  top-left column of the window.
frame_done  out  1  one-cycle pulse when the frame is complete.
size_err  out  1  sticky flag: the last start carried an illegal size.

Behaviour:
- Reset values: pix_ready=0, win_valid=0, win_data=0, win_row=0, win_col=0, frame_done=0, size_err=0. FSM=IDLE and column/row counters x,y=0. Line-buffer contents are not cleared; rows 0-1 never produce windows, so stale data is never exposed.
- FSM states: IDLE, STREAM, DRAIN.
- IDLE, on size_detection_done:
  - If 3<=image_size<=MAX_IMAGE_SIZE: latch N, clear size_err, go to STREAM.
  - Otherwise: set size_err=1 and stay in IDLE.
  - size_detection_done is ignored outside IDLE.
- pix_ready = (state==STREAM) && (!win_valid || win_ready). A pixel is accepted on pix_valid && pix_ready.
- On each accepted pixel at (y,x):
  - Shift the 3-column window registers: new column = {lb1[x], lb0[x], pix_data}, i.e. rows y-2, y-1, y.
  - Write lb1[x]<=lb0[x] and lb0[x]<=pix_data. Line-buffer reads are old-value (read-before-write).
  - Advance x; on x==N-1, set x=0 and advance y.
  - If y>=2 and x>=2: on the next cycle win_valid=1, win_data holds the window, win_row=y-2, win_col=x-2. Latency is 1 cycle from pixel accept.
  - The window registers are not reset at row start; windows with x<2 are suppressed.
- win_valid stays high with stable data until win_ready. If win_ready and a new window-producing pixel are accepted in the same cycle, the slot reloads with win_valid held at 1 (back-to-back throughput of 1 window/cycle).
- When pixel (N-1,N-1) is accepted, go to DRAIN. In DRAIN, pix_ready=0.
- DRAIN to IDLE: taken when !win_valid, or win_valid && win_ready. frame_done is asserted for exactly the first IDLE cycle.
- Total windows per frame: (N-2)^2, in raster order of the top-left coordinate.
- Reset mid-frame returns everything to reset values. Any window in flight is dropped; no frame_done is produced.
- Arithmetic: counters are MAX_IMAGE_SIZE_LOG2 bits. Comparisons against N-1 use MAX_IMAGE_SIZE_LOG2+1 bits to avoid wrap at N=MAX_IMAGE_SIZE.

Optional Feature:
CNN_WIN_STRIDE2_EN
- Defined: a window is emitted only when both win_row and win_col are even. This gives floor((N-1)/2)^2 windows per frame; non-emitting pixels still obey the same pix_ready rule.
- Undefined: stride 1 as described above.
- FSM, DRAIN and frame_done behaviour are identical in both builds.

Decomposition:
- Shared package cnn_pkg holds:
  - localparam KERNEL_SIZE=3 and WIN_ELEMS=9.
  - The typedef enum for the FSM states.
  - A function for the window element index (3*dr+dc).
- One sub-module: cnn_line_buffer, a single-row delay of MAX_IMAGE_SIZE x DATA_WIDTH with an old-value read. It is instantiated twice, for lb0 and lb1.

Test Plan:
- N=3, pixels 1..9, win_ready=1 -> exactly one window win_data={9,8,...,1} (element k=k+1), row 0, col 0. frame_done pulses once, after the window handshake.
- N=4, pixels 0..15 -> 4 windows in order (0,0),(0,1),(1,0),(1,1). Window (1,1) elements = {5,6,7,9,10,11,13,14,15}.
- N=8 with random win_ready (30% high) and random pix_valid -> 36 windows, matched bit-exactly against a scoreboard. pix_ready=0 whenever win_valid && !win_ready. win_data is stable while stalled.
- Illegal sizes: start with image_size=2 -> size_err=1 and pix_ready stays 0. Then start with image_size=600 -> size_err stays 1. Then start with image_size=5 -> size_err=0, and 9 windows are produced.
- Reset asserted at pixel 20 of an N=6 frame -> all outputs return to reset values the next cycle. A following N=3 frame produces the correct single window with no stale data.
- CNN_WIN_STRIDE2_EN defined, N=5 -> windows only at (0,0),(0,2),(2,0),(2,2), then frame_done.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared constants, FSM state type and window-element indexing for the
// cnn_window_gen sliding-window generator.
package cnn_pkg;

    localparam int KERNEL_SIZE = 3;
    localparam int WIN_ELEMS   = KERNEL_SIZE * KERNEL_SIZE;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } cnn_state_t;

    // Flat index of a window element from its row/column offset.
    function automatic int win_idx(input int dr, input int dc);
        return KERNEL_SIZE * dr + dc;
    endfunction

endpackage

// File: rtl/cnn_line_buffer.sv
// Single image-row delay line: a RAM of DEPTH words, registered read that
// returns the pre-write contents when read and write hit the same address.
module cnn_line_buffer
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 512,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data
);

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/cnn_window_gen.sv
// Streaming 3x3 window generator (valid padding) for a square raster image.
// Define CNN_WIN_STRIDE2_EN to emit only windows with even top-left row/col.
module cnn_window_gen
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH          = 32,
    parameter int MAX_IMAGE_SIZE      = 512,
    parameter int MAX_IMAGE_SIZE_LOG2 = 9
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            size_detection_done,
    input  logic [MAX_IMAGE_SIZE_LOG2:0]    image_size,
    input  logic                            pix_valid,
    output logic                            pix_ready,
    input  logic [DATA_WIDTH-1:0]           pix_data,
    output logic                            win_valid,
    input  logic                            win_ready,
    output logic [9*DATA_WIDTH-1:0]         win_data,
    output logic [MAX_IMAGE_SIZE_LOG2-1:0]  win_row,
    output logic [MAX_IMAGE_SIZE_LOG2-1:0]  win_col,
    output logic                            frame_done,
    output logic                            size_err
);

    localparam int CW   = MAX_IMAGE_SIZE_LOG2;
    localparam int SW   = MAX_IMAGE_SIZE_LOG2 + 1;
    localparam int EDGE = KERNEL_SIZE - 1;

    cnn_state_t r_state;
    cnn_state_t w_state_next;

    logic [SW-1:0]                   r_n;
    logic [CW-1:0]                   r_x;
    logic [CW-1:0]                   r_y;
    logic                            r_win_valid;
    logic [WIN_ELEMS*DATA_WIDTH-1:0] r_win_data;
    logic [CW-1:0]                   r_win_row;
    logic [CW-1:0]                   r_win_col;
    logic                            r_frame_done;
    logic                            r_size_err;

    logic                            w_pix_ready;
    logic                            w_leave_drain;
    logic                            w_accept;
    logic                            w_start_ok;
    logic                            w_win_free;
    logic                            w_x_last;
    logic                            w_y_last;
    logic                            w_emit;
    logic [CW-1:0]                   w_x_next;
    logic [CW-1:0]                   w_rd_addr;
    logic [DATA_WIDTH-1:0]           w_lb0_rd;
    logic [DATA_WIDTH-1:0]           w_lb1_rd;
    logic [DATA_WIDTH-1:0]           w_new_col [0:KERNEL_SIZE-1];
    logic [WIN_ELEMS*DATA_WIDTH-1:0] w_win_flat;

    assign w_win_free = !r_win_valid || win_ready;
    assign w_accept   = pix_valid && w_pix_ready;
    assign w_start_ok = (image_size >= SW'(KERNEL_SIZE)) && (image_size <= SW'(MAX_IMAGE_SIZE));
    assign w_x_last   = ({1'b0, r_x} == (r_n - SW'(1)));
    assign w_y_last   = ({1'b0, r_y} == (r_n - SW'(1)));
    assign w_x_next   = w_x_last ? '0 : r_x + CW'(1);

    // The RAM read is registered, so the address of the next pixel column is
    // presented one cycle early; reads never collide with the current write.
    assign w_rd_addr  = w_accept ? w_x_next : r_x;

`ifdef CNN_WIN_STRIDE2_EN
    assign w_emit = w_accept && (r_y >= CW'(EDGE)) && (r_x >= CW'(EDGE)) && !r_y[0] && !r_x[0];
`else
    assign w_emit = w_accept && (r_y >= CW'(EDGE)) && (r_x >= CW'(EDGE));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_pix_ready   = 1'b0;
        w_leave_drain = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (size_detection_done && w_start_ok) begin
                    w_state_next = ST_STREAM;
                end
            end
            ST_STREAM: begin
                w_pix_ready = w_win_free;
                if (pix_valid && w_win_free && w_x_last && w_y_last) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_win_free) begin
                    w_state_next  = ST_IDLE;
                    w_leave_drain = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_n          <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_size_err   <= 1'b0;
            r_frame_done <= 1'b0;
            r_win_valid  <= 1'b0;
            r_win_data   <= '0;
            r_win_row    <= '0;
            r_win_col    <= '0;
        end else begin
            r_frame_done <= w_leave_drain;

            if ((r_state == ST_IDLE) && size_detection_done) begin
                if (w_start_ok) begin
                    r_n        <= image_size;
                    r_size_err <= 1'b0;
                    r_x        <= '0;
                    r_y        <= '0;
                end else begin
                    r_size_err <= 1'b1;
                end
            end

            if (w_accept) begin
                r_x <= w_x_next;
                if (w_x_last) begin
                    r_y <= w_y_last ? '0 : r_y + CW'(1);
                end
            end

            if (w_emit) begin
                r_win_valid <= 1'b1;
                r_win_data  <= w_win_flat;
                r_win_row   <= r_y - CW'(EDGE);
                r_win_col   <= r_x - CW'(EDGE);
            end else if (win_ready) begin
                r_win_valid <= 1'b0;
            end
        end
    end

    // Incoming column, top to bottom: rows y-2, y-1, y.
    assign w_new_col[0] = w_lb1_rd;
    assign w_new_col[1] = w_lb0_rd;
    assign w_new_col[2] = pix_data;

    genvar gi;
    generate
        for (gi = 0; gi < KERNEL_SIZE; gi++) begin : g_row
            logic [DATA_WIDTH-1:0] r_tap0;
            logic [DATA_WIDTH-1:0] r_tap1;

            always_ff @(posedge clk) begin
                if (w_accept) begin
                    r_tap0 <= r_tap1;
                    r_tap1 <= w_new_col[gi];
                end
            end

            assign w_win_flat[win_idx(gi, 0)*DATA_WIDTH +: DATA_WIDTH] = r_tap0;
            assign w_win_flat[win_idx(gi, 1)*DATA_WIDTH +: DATA_WIDTH] = r_tap1;
            assign w_win_flat[win_idx(gi, 2)*DATA_WIDTH +: DATA_WIDTH] = w_new_col[gi];
        end
    endgenerate

    // lb0 holds row y-1, lb1 holds row y-2; lb1 is fed from lb0's old value.
    cnn_line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MAX_IMAGE_SIZE),
        .ADDR_WIDTH (CW)
    ) u_lb0 (
        .clk       (clk),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_lb0_rd),
        .i_wr_en   (w_accept),
        .i_wr_addr (r_x),
        .i_wr_data (pix_data)
    );

    cnn_line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MAX_IMAGE_SIZE),
        .ADDR_WIDTH (CW)
    ) u_lb1 (
        .clk       (clk),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_lb1_rd),
        .i_wr_en   (w_accept),
        .i_wr_addr (r_x),
        .i_wr_data (w_lb0_rd)
    );

    assign pix_ready  = w_pix_ready;
    assign win_valid  = r_win_valid;
    assign win_data   = r_win_data;
    assign win_row    = r_win_row;
    assign win_col    = r_win_col;
    assign frame_done = r_frame_done;
    assign size_err   = r_size_err;

endmodule

// File: tb/tb_cnn_window_gen.sv
// Self-checking bench for cnn_window_gen: randomized handshakes checked
// against a window list computed directly from the stored image.
`timescale 1ns/1ps
module tb_cnn_window_gen;

    localparam int DW = 32;
    localparam int L2 = 9;
    localparam int SW = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              sdd;
    logic [SW-1:0]     image_size;
    logic              pix_valid;
    logic              pix_ready;
    logic [DW-1:0]     pix_data;
    logic              win_valid;
    logic              win_ready;
    logic [9*DW-1:0]   win_data;
    logic [L2-1:0]     win_row;
    logic [L2-1:0]     win_col;
    logic              frame_done;
    logic              size_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cnn_window_gen #(
        .DATA_WIDTH          (DW),
        .MAX_IMAGE_SIZE      (512),
        .MAX_IMAGE_SIZE_LOG2 (L2)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .size_detection_done (sdd),
        .image_size          (image_size),
        .pix_valid           (pix_valid),
        .pix_ready           (pix_ready),
        .pix_data            (pix_data),
        .win_valid           (win_valid),
        .win_ready           (win_ready),
        .win_data            (win_data),
        .win_row             (win_row),
        .win_col             (win_col),
        .frame_done          (frame_done),
        .size_err            (size_err)
    );

    typedef struct {
        int            row;
        int            col;
        logic [9*DW-1:0] data;
    } win_t;

    win_t          exp_q[$];
    logic [DW-1:0] img [0:63];

    // Reference: every valid-padding window of the image, raster order.
    task automatic build_expected(input int n);
        int   step;
        win_t w;
`ifdef CNN_WIN_STRIDE2_EN
        step = 2;
`else
        step = 1;
`endif
        exp_q.delete();
        for (int r = 0; r <= n - 3; r += step) begin
            for (int c = 0; c <= n - 3; c += step) begin
                w.row  = r;
                w.col  = c;
                w.data = '0;
                for (int k = 0; k < 9; k++) begin
                    w.data[k*DW +: DW] = img[(r + k / 3) * n + c + k % 3];
                end
                exp_q.push_back(w);
            end
        end
    endtask

    task automatic start_frame(input int size);
        @(negedge clk);
        sdd        = 1'b1;
        image_size = SW'(size);
        @(negedge clk);
        sdd        = 1'b0;
    endtask

    task automatic run_frame(input int n, input int vprob, input int rprob,
                             input int stop_at, input string tag);
        int              idx = 0;
        int              got = 0;
        int              fd = 0;
        int              cyc = 0;
        int              nexp;
        bit              done = 0;
        logic            prev_stall = 1'b0;
        logic [9*DW-1:0] prev_data = '0;
        win_t            e;
        build_expected(n);
        nexp = exp_q.size();
        while (!done) begin
            pix_valid = (idx < n * n) && ($urandom_range(99) < vprob);
            pix_data  = (idx < n * n) ? img[idx] : $urandom;
            win_ready = ($urandom_range(99) < rprob);
            #1;
            if (prev_stall) begin
                checks++;
                if (win_data !== prev_data) begin
                    errors++;
                    $display("FAIL %s stall_stable got=%h exp=%h", tag, win_data, prev_data);
                end
            end
            if (win_valid && !win_ready) begin
                checks++;
                if (pix_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s backpressure pix_ready got=%b exp=0", tag, pix_ready);
                end
            end
            if (win_valid && win_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s extra_window got row=%0d col=%0d exp none", tag, win_row, win_col);
                end else begin
                    e = exp_q.pop_front();
                    if (win_row !== L2'(e.row) || win_col !== L2'(e.col) || win_data !== e.data) begin
                        errors++;
                        $display("FAIL %s window got (%0d,%0d) %h exp (%0d,%0d) %h",
                                 tag, win_row, win_col, win_data, e.row, e.col, e.data);
                    end else begin
                        $display("%s window (%0d,%0d) ok", tag, win_row, win_col);
                    end
                end
                got++;
            end
            if (pix_valid && pix_ready) idx++;
            if (frame_done) begin
                fd++;
                checks++;
                if (got != nexp || idx != n * n) begin
                    errors++;
                    $display("FAIL %s frame_done_order got windows=%0d pixels=%0d exp windows=%0d pixels=%0d",
                             tag, got, idx, nexp, n * n);
                end
                done = 1;
            end
            prev_stall = win_valid && !win_ready;
            prev_data  = win_data;
            if (stop_at >= 0 && idx >= stop_at) done = 1;
            cyc++;
            if (cyc > 5000) begin
                checks++;
                errors++;
                $display("FAIL %s timeout got windows=%0d exp=%0d", tag, got, nexp);
                done = 1;
            end
            @(negedge clk);
        end
        if (stop_at < 0) begin
            checks++;
            if (got != nexp) begin
                errors++;
                $display("FAIL %s window_count got=%0d exp=%0d", tag, got, nexp);
            end
            checks++;
            if (fd != 1) begin
                errors++;
                $display("FAIL %s frame_done_count got=%0d exp=1", tag, fd);
            end
            #1;
            checks++;
            if (frame_done !== 1'b0) begin
                errors++;
                $display("FAIL %s frame_done_width got=%b exp=0", tag, frame_done);
            end
        end
        pix_valid = 1'b0;
        win_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (pix_ready !== 1'b0 || win_valid !== 1'b0 || win_data !== '0 || win_row !== '0 ||
            win_col !== '0 || frame_done !== 1'b0 || size_err !== 1'b0) begin
            errors++;
            $display("FAIL %s reset_outputs got rdy=%b wv=%b wd=%h row=%0d col=%0d fd=%b se=%b exp all zero",
                     tag, pix_ready, win_valid, win_data, win_row, win_col, frame_done, size_err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; sdd = 1'b0; image_size = '0;
        pix_valid = 1'b0; pix_data = '0; win_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
    endtask

    task automatic test_n3();
        for (int i = 0; i < 9; i++) img[i] = DW'(i + 1);
        start_frame(3);
        run_frame(3, 100, 100, -1, "n3");
    endtask

    task automatic test_n4();
        for (int i = 0; i < 16; i++) img[i] = DW'(i);
        start_frame(4);
        run_frame(4, 100, 100, -1, "n4");
    endtask

    task automatic test_random_n8();
        for (int i = 0; i < 64; i++) img[i] = $urandom;
        start_frame(8);
        run_frame(8, 60, 30, -1, "n8rand");
    endtask

    task automatic test_illegal_sizes();
        start_frame(2);
        #1;
        checks++;
        if (size_err !== 1'b1) begin
            errors++;
            $display("FAIL size2 size_err got=%b exp=1", size_err);
        end
        pix_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (pix_ready !== 1'b0) begin
                errors++;
                $display("FAIL size2 pix_ready got=%b exp=0", pix_ready);
            end
        end
        pix_valid = 1'b0;
        start_frame(600);
        #1;
        checks++;
        if (size_err !== 1'b1) begin
            errors++;
            $display("FAIL size600 size_err got=%b exp=1", size_err);
        end
        for (int i = 0; i < 25; i++) img[i] = $urandom;
        start_frame(5);
        #1;
        checks++;
        if (size_err !== 1'b0) begin
            errors++;
            $display("FAIL size5 size_err got=%b exp=0", size_err);
        end
        run_frame(5, 80, 70, -1, "n5");
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 36; i++) img[i] = $urandom;
        start_frame(6);
        run_frame(6, 100, 100, 20, "n6abort");
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 9; i++) img[i] = $urandom;
        start_frame(3);
        run_frame(3, 100, 100, -1, "n3post");
    endtask

`ifdef CNN_WIN_STRIDE2_EN
    task automatic test_stride2();
        for (int i = 0; i < 25; i++) img[i] = DW'(100 + i);
        start_frame(5);
        run_frame(5, 90, 50, -1, "stride2");
    endtask
`endif

    initial begin
        test_reset();
        test_n3();
        test_n4();
        test_random_n8();
        test_illegal_sizes();
        test_mid_reset();
`ifdef CNN_WIN_STRIDE2_EN
        test_stride2();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
